wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage: drives the register-file write port (regwrite, writereg, writedata).
- Registers MEM-stage results (MEM/WB pipeline register) and applies load byte/half extraction and extension.
- Merges results from the long-latency mult/div unit through a small FIFO and write-port arbiter.
- Pipeline writes have priority. A starvation guard requests a bubble so queued mult/div results always drain.

Parameters:
- MD_FIFO_DEPTH, 2, mult/div result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive denied cycles with a non-empty FIFO before stall_req asserts; at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_regwrite  in  1  instruction writes a register.
- mem_writereg  in  5  destination register.
- mem_memtoreg  in  1  1 = load data, 0 = ALU result.
- mem_alu_result  in  32  ALU result.
- mem_load_data  in  32  raw aligned word from data memory.
- mem_load_type  in  3  LW/LB/LBU/LH/LHU code (package enum).
- mem_byte_off  in  2  address bits [1:0].
- stall  in  1  hazard unit holds MEM; WB receives a bubble.
- flush  in  1  squash the MEM instruction.
- md_valid  in  1  mult/div result offered.
- md_ready  out  1  FIFO can accept a result.
- md_writereg  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- regwrite  out  1  register-file write enable.
- writereg  out  5  register-file write address.
- writedata  out  32  register-file write data.
- wb_src_md  out  1  current write comes from the FIFO (for forwarding and debug).
- stall_req  out  1  request to hazard unit to bubble MEM.

Behaviour:
- Reset (async): WB register = bubble, FIFO empty, starvation counter 0. This gives regwrite=0, writereg=0, writedata=0, wb_src_md=0, stall_req=0, md_ready=1.
- WB register load, each rising edge:
  - If stall, flush or stall_req is high: load a bubble (valid=0).
  - Otherwise capture: valid = mem_valid & mem_regwrite & (mem_writereg != 0), plus reg and data.
  - Every instruction therefore writes exactly once.
- Data select, computed before the register:
  - mem_memtoreg=0 gives mem_alu_result.
  - Otherwise extract from the little-endian word; byte k = bits [8k+7:8k].
  - LB/LBU use byte mem_byte_off, sign-extended / zero-extended.
  - LH/LHU use half mem_byte_off[1], sign-extended / zero-extended; mem_byte_off[0] ignored.
  - LW ignores mem_byte_off.
  - Undefined load codes behave as LW.
- Latency: MEM inputs to regwrite is 1 cycle.
- Write-port arbitration, combinational from registered state:
  - WB register valid: outputs = WB register, wb_src_md=0.
  - Else FIFO non-empty: outputs = FIFO head, wb_src_md=1, head pops at the clock edge.
  - Else regwrite=0; writereg and writedata hold their previous values, driven from the held WB register.
- FIFO push:
  - Push when md_valid & md_ready.
  - md_ready = !full, taken from the registered count only. When full, no push occurs even in a cycle that pops.
  - Entries with md_writereg=0 are accepted and discarded (not stored).
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Pointers wrap modulo MD_FIFO_DEPTH.
- Starvation guard:
  - Counter increments when the FIFO is non-empty and the port is taken by the WB register.
  - Counter clears on any FIFO pop, and when the FIFO is empty.
  - stall_req is registered. It sets when counter+1 = STARVE_LIMIT and clears on the cycle after a pop.
  - While stall_req is high, the WB register loads bubbles, so the head drains within 2 cycles of stall_req rising.
- Register 0: regwrite is never asserted with writereg=0.
- Reset mid-operation: queued FIFO results are lost and the pending write is cancelled. The mult/div unit is reset alongside.

Decomposition:
- Package wb_pkg:
  - load_type_t enum: LT_LW=0, LT_LB=1, LT_LBU=2, LT_LH=3, LT_LHU=4.
  - REG_ZERO=5'd0.
  - Function load_extend(word, type, off).
- Sub-module md_result_fifo:
  - Parameterised depth, 37-bit entries (reg + data).
  - Ports: push, pop, full, empty, head.

Test Plan:
- Reset then idle → regwrite=0, md_ready=1, stall_req=0; FIFO empty.
- ALU write: mem_valid=1, regwrite=1, reg=5, alu=0x12345678 → next cycle regwrite=1, writereg=5, writedata=0x12345678. The same input with reg=0 → regwrite stays 0.
- Loads with word 0x80FF7F01:
  - LB off=2 → 0xFFFFFFFF; LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80FF; LHU off=0 → 0x00007F01; LW → 0x80FF7F01.
- Stall/flush: stall=1 while a valid write is presented → next cycle regwrite=0. flush=1 → bubble, no write.
- Mult/div drain: idle pipeline, md result reg=8, data=0xDEADBEEF → regwrite=1 with wb_src_md=1 the next cycle. With two pushes plus a third offered, md_ready=0 when full and FIFO order is preserved.
- Starvation: continuous pipeline writes while the FIFO holds 1 entry, STARVE_LIMIT=4 → stall_req rises after 4 denied cycles; the next WB is a bubble and the FIFO entry is written; stall_req then falls.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Writeback-stage types, constants and load extraction helper.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         MD_ENTRY_W = 37;

    // Byte k of the little-endian word lives in bits [8k+7:8k]; undefined codes act as LW.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [2:0]  ltype,
        input logic [1:0]  off
    );
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        w_byte = 8'(word >> {off, 3'b000});
        w_half = 16'(word >> {off[1], 4'b0000});
        case (ltype)
            LT_LB:   return {{24{w_byte[7]}}, w_byte};
            LT_LBU:  return {24'd0, w_byte};
            LT_LH:   return {{16{w_half[15]}}, w_half};
            LT_LHU:  return {16'd0, w_half};
            default: return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : md_result_fifo
// Brief    : Small power-of-two FIFO holding {reg, data} mult/div results.
// Revision : 1.0 - initial release
// ============================================================================
module md_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign full  = (r_count == c_cnt_w'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : MEM/WB register, load extension, mult/div result merge and
//            starvation guard driving the register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int MD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_writereg,
    input  logic        mem_memtoreg,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_byte_off,
    input  logic        stall,
    input  logic        flush,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_writereg,
    input  logic [31:0] md_data,
    output logic        regwrite,
    output logic [4:0]  writereg,
    output logic [31:0] writedata,
    output logic        wb_src_md,
    output logic        stall_req
);

    localparam int                 c_cnt_w    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STARVE_LIMIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STARVE_LIMIT);

    logic        r_wb_valid;
    logic [4:0]  r_wb_reg;
    logic [31:0] r_wb_data;
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic        r_stall_req;

    logic [31:0]           w_mem_data;
    logic                  w_wb_load;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [MD_ENTRY_W-1:0] w_fifo_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_denied;

    assign w_mem_data = mem_memtoreg ? load_extend(mem_load_data, mem_load_type, mem_byte_off)
                                     : mem_alu_result;
    assign w_wb_load  = !(stall || flush || r_stall_req);

    // A bubble keeps the previous reg/data so an idle port holds its last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= REG_ZERO;
            r_wb_data  <= '0;
        end else if (w_wb_load) begin
            r_wb_valid <= mem_valid && mem_regwrite && (mem_writereg != REG_ZERO);
            r_wb_reg   <= mem_writereg;
            r_wb_data  <= w_mem_data;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    // Writes to register 0 are accepted from the unit but never stored.
    assign md_ready = !w_fifo_full;
    assign w_push   = md_valid && md_ready && (md_writereg != REG_ZERO);
    assign w_pop    = !r_wb_valid && !w_fifo_empty;
    assign w_denied = r_wb_valid && !w_fifo_empty;

    md_result_fifo #(
        .DEPTH (MD_FIFO_DEPTH),
        .WIDTH (MD_ENTRY_W)
    ) u_md_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data ({md_writereg, md_data}),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    always_comb begin
        regwrite  = r_wb_valid;
        writereg  = r_wb_reg;
        writedata = r_wb_data;
        wb_src_md = 1'b0;
        if (w_pop) begin
            regwrite  = 1'b1;
            writereg  = w_fifo_head[36:32];
            writedata = w_fifo_head[31:0];
            wb_src_md = 1'b1;
        end
    end

    // stall_req holds until the bubble it forced lets the head drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else begin
            if (w_pop || w_fifo_empty) begin
                r_starve_cnt <= '0;
            end else if (w_denied && (r_starve_cnt != c_cnt_max)) begin
                r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
            end

            if (w_pop) begin
                r_stall_req <= 1'b0;
            end else if (w_denied && (r_starve_cnt == c_cnt_last)) begin
                r_stall_req <= 1'b1;
            end
        end
    end

    assign stall_req = r_stall_req;

endmodule
`default_nettype wire
